// File: rtl/user_irq_pkg.sv
// Shared constants for the user interrupt generator: register offsets,
// STATUS/CTRL bit positions, irq line indices and byte-enable helpers.
// Pure declarations; no logic, no latency, no flow control.
package user_irq_pkg;

    // Register byte offsets inside the 256-byte Wishbone window
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LOAD   = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_EDGE   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_MASK   = 8'h14;
    localparam logic [7:0] OFF_SWSET  = 8'h18;

    // STATUS / MASK bit positions
    localparam int ST_TIMER    = 0;
    localparam int ST_EDGE_LSB = 8;
    localparam int ST_SW       = 31;

    // CTRL bit positions
    localparam int CTRL_TEN  = 0;
    localparam int CTRL_AUTO = 1;

    // EDGE register: rise enables at bit 0, fall enables at this offset
    localparam int EDGE_FALL_LSB = 16;

    // irq line indices
    localparam int IRQ_TIMER = 0;
    localparam int IRQ_EDGE  = 1;
    localparam int IRQ_SW    = 2;

    // Expand 4 byte enables into a 32-bit write mask
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Implemented STATUS/MASK bits for a given source count
    function automatic logic [31:0] status_bits(input int nsrc);
        logic [31:0] m;
        m = '0;
        m[ST_TIMER] = 1'b1;
        m[ST_SW]    = 1'b1;
        for (int i = 0; i < nsrc; i++) begin
            m[ST_EDGE_LSB + i] = 1'b1;
        end
        return m;
    endfunction

    // Implemented EDGE bits for a given source count
    function automatic logic [31:0] edge_bits(input int nsrc);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nsrc; i++) begin
            m[i]                 = 1'b1;
            m[EDGE_FALL_LSB + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/user_irq_edge_sync.sv
// Per-source 2-flop synchronizer, history flop and rise/fall detectors.
// Latency: input sampled at edge S shows as a 1-cycle rise_o/fall_o pulse after S+1.
// No backpressure; pulses shorter than a clock period may be lost.
// Ports: clk_i/rst_i clock and async active-high reset, src_i async input,
//        rise_o/fall_o one-cycle edge pulses of the synchronized signal.
module user_irq_edge_sync
    import user_irq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_o =  sync2_q & ~hist_q;
    assign fall_o = ~sync2_q &  hist_q;

endmodule

// File: rtl/user_irq_gen.sv
// Wishbone-programmable interrupt source: timer, edge detectors and software bit.
// Latency: ack one cycle after a hit; irq_o registered one cycle after STATUS.
// No stall: every hit is acked next cycle; a strobe held during ack is ignored.
// Ports: wb_clk_i/wb_rst_i clock and async reset; wbs_* Wishbone slave;
//        src_i asynchronous edge inputs; irq_o {software, edge group, timer}.
module user_irq_gen
    import user_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          NSRC     = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [NSRC-1:0] src_i,
    output logic [2:0]      irq_o
);

    localparam logic [31:0] ST_VALID   = status_bits(NSRC);
    localparam logic [31:0] EDGE_VALID = edge_bits(NSRC);

    logic [1:0]  ctrl_q,   ctrl_d;
    logic [31:0] load_q,   load_d;
    logic [31:0] count_q,  count_d;
    logic [31:0] edge_q,   edge_d;
    logic [31:0] status_q, status_d;
    logic [31:0] mask_q,   mask_d;
    logic [2:0]  irq_q,    irq_d;
    logic        ack_q,    ack_d;
    logic [31:0] dat_q,    dat_d;

    logic        hit;
    logic        wr;
    logic [7:0]  off;
    logic [31:0] wmask;
    logic [31:0] w1c;
    logic [31:0] hw_set;
    logic [31:0] rdata;
    logic        timer_fire;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] fall;
    logic [NSRC-1:0] edge_hit;

    // The ~ack_q term keeps a strobe still held in the ack cycle from
    // counting as a second request.
    assign hit   = wbs_cyc_i & wbs_stb_i & ~ack_q &
                   (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr    = hit & wbs_we_i;
    assign off   = wbs_adr_i[7:0];
    assign wmask = sel_mask(wbs_sel_i);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        user_irq_edge_sync u_sync (
            .clk_i  (wb_clk_i),
            .rst_i  (wb_rst_i),
            .src_i  (src_i[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    assign edge_hit   = (rise & edge_q[NSRC-1:0]) |
                        (fall & edge_q[EDGE_FALL_LSB +: NSRC]);
    assign timer_fire = ctrl_q[CTRL_TEN] & (count_q == 32'd0);

    always_comb begin
        hw_set                        = '0;
        hw_set[ST_TIMER]              = timer_fire;
        hw_set[ST_EDGE_LSB +: NSRC]   = edge_hit;
        hw_set[ST_SW]                 = wr & (off == OFF_SWSET) &
                                        wbs_sel_i[0] & wbs_dat_i[0];
    end

    always_comb begin
        ctrl_d = ctrl_q;
        load_d = load_q;
        edge_d = edge_q;
        mask_d = mask_q;
        w1c    = '0;

        // One-shot expiry drops TEN; a CTRL write in the same cycle overrides.
        if (timer_fire && !ctrl_q[CTRL_AUTO]) begin
            ctrl_d[CTRL_TEN] = 1'b0;
        end

        if (wr) begin
            case (off)
                OFF_CTRL:   ctrl_d = (ctrl_d & ~wmask[1:0]) | (wbs_dat_i[1:0] & wmask[1:0]);
                OFF_LOAD:   load_d = (load_q & ~wmask) | (wbs_dat_i & wmask);
                OFF_EDGE:   edge_d = ((edge_q & ~wmask) | (wbs_dat_i & wmask)) & EDGE_VALID;
                OFF_STATUS: w1c    = wbs_dat_i & wmask;
                OFF_MASK:   mask_d = ((mask_q & ~wmask) | (wbs_dat_i & wmask)) & ST_VALID;
                default:    ;
            endcase
        end

        // Timer: load on TEN 0->1, otherwise count down / reload / hold at 0
        count_d = count_q;
        if (!ctrl_q[CTRL_TEN] && ctrl_d[CTRL_TEN]) begin
            count_d = load_q;
        end else if (ctrl_q[CTRL_TEN]) begin
            if (count_q == 32'd0) begin
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = load_q;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        // Hardware sets win over a same-cycle W1C
        status_d = ((status_q & ~w1c) | hw_set) & ST_VALID;

        irq_d            = '0;
        irq_d[IRQ_TIMER] = status_q[ST_TIMER] & mask_q[ST_TIMER];
        irq_d[IRQ_EDGE]  = |(status_q[ST_EDGE_LSB +: NSRC] & mask_q[ST_EDGE_LSB +: NSRC]);
        irq_d[IRQ_SW]    = status_q[ST_SW] & mask_q[ST_SW];
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = {30'd0, ctrl_q};
            OFF_LOAD:   rdata = load_q;
            OFF_COUNT:  rdata = count_q;
            OFF_EDGE:   rdata = edge_q;
            OFF_STATUS: rdata = status_q;
            OFF_MASK:   rdata = mask_q;
            default:    rdata = '0;
        endcase
        ack_d = hit;
        dat_d = (hit && !wbs_we_i) ? rdata : 32'd0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q   <= '0;
            load_q   <= '0;
            count_q  <= '0;
            edge_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            edge_q   <= edge_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_user_irq_gen.sv
// Directed bench for user_irq_gen: reset, timer one-shot/auto, edges,
// software irq with masking, and bus decode corners.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_user_irq_gen;

    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [7:0]  src;
    logic [2:0]  irq;
    logic [2:0]  irq_at_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    user_irq_gen dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .src_i     (src),
        .irq_o     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One transfer presented for one cycle, then one idle cycle.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got_ack, output logic [31:0] r);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(negedge clk);
        got_ack    = ack;
        r          = dat_r;
        irq_at_ack = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic        a;
        logic [31:0] r;
        wb_xfer(1'b1, B | {24'd0, off}, d, 4'hF, a, r);
        chk("wr_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] r);
        logic a;
        wb_xfer(1'b0, B | {24'd0, off}, 32'd0, 4'hF, a, r);
        chk("rd_ack", {31'd0, a}, 32'd1);
    endtask

    logic [31:0] r;
    logic        a;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat_w = '0; src = '0; irq_at_ack = '0;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        // ---- reset mid-cycle, during an ack ----
        wr(8'h18, 32'd1);
        wr(8'h14, 32'h8000_0000);
        chk("pre_rst_irq2", {29'd0, irq}, 32'd4);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B | 32'h14; sel = 4'hF;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'd0, ack}, 32'd1);
        chk("pre_rst_dat", dat_r, 32'h8000_0000);
        #1 rst = 1'b1;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_irq", {29'd0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rd(8'(i * 4), r);
            chk("rst_reg", r, 32'd0);
        end

        // ---- timer one-shot: LOAD=10, irq 12 edges after CTRL write ----
        wr(8'h14, 32'd1);
        wr(8'h04, 32'd10);
        wr(8'h00, 32'd1);          // write edge E; returns after E+1
        cycles(10);                // after E+11
        chk("t1_before", {31'd0, irq[0]}, 32'd0);
        cycles(1);                 // after E+12
        chk("t1_rise", {31'd0, irq[0]}, 32'd1);
        rd(8'h00, r);
        chk("t1_ctrl", r, 32'd0);
        rd(8'h08, r);
        chk("t1_count", r, 32'd0);
        rd(8'h10, r);
        chk("t1_status", r, 32'd1);
        wr(8'h10, 32'd1);
        chk("t1_irq_at_clr", {31'd0, irq_at_ack[0]}, 32'd1);
        chk("t1_irq_fall", {31'd0, irq[0]}, 32'd0);

        // ---- timer auto-reload: LOAD=4, period 5 ----
        wr(8'h04, 32'd4);
        wr(8'h00, 32'd3);          // E; sets at E+5, E+10, E+15
        cycles(4);                 // after E+5
        chk("ar_irq_e5", {31'd0, irq[0]}, 32'd0);
        cycles(1);                 // after E+6
        chk("ar_irq_e6", {31'd0, irq[0]}, 32'd1);
        wr(8'h10, 32'd1);          // clear at E+7
        chk("ar_irq_e8", {31'd0, irq[0]}, 32'd0);
        cycles(2);                 // after E+10
        chk("ar_irq_e10", {31'd0, irq[0]}, 32'd0);
        cycles(1);                 // after E+11
        chk("ar_irq_e11", {31'd0, irq[0]}, 32'd1);
        wr(8'h10, 32'd1);          // clear at E+12
        cycles(1);
        wr(8'h10, 32'd1);          // W1C at E+15, same edge as the set
        rd(8'h10, r);
        chk("ar_set_wins", r, 32'd1);
        wr(8'h00, 32'd0);
        wr(8'h10, 32'hFFFF_FFFF);

        // ---- edge detection ----
        wr(8'h14, 32'h0000_0100);
        wr(8'h0C, 32'h0000_0001);
        src[0] = 1'b1;
        cycles(1);                 // after S
        cycles(2);                 // after S+2
        chk("edge_irq_s2", {31'd0, irq[1]}, 32'd0);
        cycles(1);                 // after S+3
        chk("edge_irq_s3", {31'd0, irq[1]}, 32'd1);
        wr(8'h10, 32'h0000_0100);
        src[0] = 1'b0;
        cycles(5);
        rd(8'h10, r);
        chk("edge_fall_off", r, 32'd0);
        chk("edge_fall_irq", {31'd0, irq[1]}, 32'd0);
        wr(8'h0C, 32'h0001_0000);
        src[0] = 1'b1;
        cycles(5);
        rd(8'h10, r);
        chk("edge_rise_off", r, 32'd0);
        src[0] = 1'b0;
        cycles(5);
        rd(8'h10, r);
        chk("edge_fall_on", r, 32'h0000_0100);
        chk("edge_fall_on_irq", {31'd0, irq[1]}, 32'd1);
        wr(8'h10, 32'hFFFF_FFFF);
        wr(8'h0C, 32'd0);

        // ---- software irq and masking ----
        wr(8'h14, 32'd0);
        wr(8'h18, 32'd1);
        rd(8'h10, r);
        chk("sw_status", r, 32'h8000_0000);
        chk("sw_masked", {31'd0, irq[2]}, 32'd0);
        rd(8'h18, r);
        chk("sw_rd_zero", r, 32'd0);
        wr(8'h14, 32'h8000_0000);
        chk("sw_irq_at_mask", {31'd0, irq_at_ack[2]}, 32'd0);
        chk("sw_irq_on", {31'd0, irq[2]}, 32'd1);

        // ---- bus corners ----
        rd(8'h1C, r);
        chk("unmapped_rd", r, 32'd0);
        wb_xfer(1'b0, B + 32'h100, 32'd0, 4'hF, a, r);
        chk("out_of_window", {31'd0, a}, 32'd0);
        wr(8'h04, 32'd0);
        wb_xfer(1'b1, B | 32'h04, 32'hFFFF_FFFF, 4'b0001, a, r);
        chk("sel_ack", {31'd0, a}, 32'd1);
        rd(8'h04, r);
        chk("sel_load", r, 32'h0000_00FF);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B; sel = 4'hF;
        @(negedge clk);
        chk("held_ack1", {31'd0, ack}, 32'd1);
        @(negedge clk);
        chk("held_ack2", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/user_irq_gen.md
# user_irq_gen

Wishbone-programmable interrupt source block inside the user project wrapper. It drives the three `user_irq` lines into the management SoC from three sources: a down-counting timer, edge detectors on `NSRC` user I/O inputs, and a software-set bit. Firmware configures it over the wrapper's Wishbone slave port. The firmware IRQ test uses it to raise interrupts and report progress on the status GPIOs.

## Interface
- `BASE_ADR`, default 32'h3000_0000: Wishbone window base; the block decodes `adr[31:8]`.
- `NSRC`, default 8: number of edge-detected inputs; legal range 1..16.
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wbs_cyc_i` in 1, `wbs_stb_i` in 1, `wbs_we_i` in 1: Wishbone cycle, strobe and write enable.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32, `wbs_dat_i` in 32: address and write data.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: acknowledge and read data.
- `src_i` in NSRC: asynchronous interrupt inputs, taken from `io_in`.
- `irq_o` out 3: `irq_o[0]` timer, `irq_o[1]` edge group, `irq_o[2]` software. Connects to `user_irq`.

## Operation
- Register map, by byte offset:
  - 0x00 CTRL: bit0 `TEN`, bit1 `AUTO`.
  - 0x04 LOAD: 32-bit timer reload value.
  - 0x08 COUNT: read-only.
  - 0x0C EDGE: bits [NSRC-1:0] rise enables, bits [16+NSRC-1:16] fall enables.
  - 0x10 STATUS: W1C. Bit0 timer, bits [8+NSRC-1:8] edge sources, bit31 software.
  - 0x14 MASK: same bit layout as STATUS.
  - 0x18 SWSET: write 1 to bit0 sets STATUS[31]; reads return 0.
  - Unmapped offsets inside the window: acknowledge; reads return 0; writes are ignored.
- Wishbone behaviour:
  - A transfer hits when `cyc & stb` and `adr[31:8]==BASE_ADR[31:8]`.
  - `ack` is a 1-cycle pulse in the cycle after a hit. Read data is valid in the same cycle as `ack`.
  - `ack` is never asserted in two consecutive cycles. A strobe still held while `ack` is high is not a new request.
  - Writes honour `sel_i` per byte.
  - Addresses outside the window are never acknowledged.
- Timer:
  - A write that takes `TEN` from 0 to 1 loads COUNT from LOAD.
  - While `TEN`=1, COUNT decrements by 1 per cycle.
  - When COUNT==0 with `TEN`=1, STATUS[0] is set. Then:
    - if `AUTO`=1, COUNT reloads from LOAD;
    - if `AUTO`=0, `TEN` is cleared by hardware and COUNT holds at 0.
  - LOAD=0 with `AUTO`=1 fires every cycle.
  - Writing `TEN`=0 freezes COUNT.
- Edge detection:
  - Each `src_i` bit passes through a 2-flop synchronizer plus a history flop.
  - A rising or falling edge of the synchronized signal sets `STATUS[8+i]` if that edge type is enabled.
- Outputs:
  - `irq_o[0]` = STATUS[0] & MASK[0].
  - `irq_o[1]` = OR over i of STATUS[8+i] & MASK[8+i].
  - `irq_o[2]` = STATUS[31] & MASK[31].
  - All three are registered. They are level outputs, held until cleared or masked.
- Simultaneous events:
  - A hardware set and a W1C of the same bit in the same cycle: the set wins and the bit stays 1.
  - A SWSET write and a W1C of bit31 in the same cycle: the set wins.
- Reset: all registers, COUNT, synchronizers, `wbs_ack_o`, `wbs_dat_o` and `irq_o` go to 0. Reset mid-transaction drops the `ack`.

## Timing
- Wishbone access latency: 1 cycle from a hit to `ack`.
- Timer, LOAD=N and `TEN` written at edge E:
  - COUNT=N after E; COUNT reaches 0 at edge E+N.
  - STATUS[0] is set at edge E+N+1.
  - `irq_o[0]` rises at edge E+N+2.
- Timer period with `AUTO`=1: N+1 cycles.
- Edges: a `src_i` transition sampled at edge S sets STATUS at edge S+2; `irq_o[1]` rises at edge S+3.
- Pulses on `src_i` shorter than one clock period may be missed.
- Clear and mask effects:
  - A W1C with `ack` at edge A clears the STATUS bit at A; the irq line falls at A+1.
  - A MASK write takes effect on `irq_o` one cycle after its STATUS effect would appear.

## Structure
- Package `user_irq_pkg` holds:
  - register offset constants (CTRL..SWSET);
  - STATUS bit positions: `ST_TIMER`=0, `ST_EDGE_LSB`=8, `ST_SW`=31;
  - CTRL bit positions;
  - irq line indices.
- Sub-module `user_irq_edge_sync`, one instance per source. It contains the synchronizer, history flop and rise/fall detect outputs.
- The timer and register file live in the top module.

## Test plan
- Reset: assert `wb_rst_i` asynchronously mid-cycle -> all outputs are 0 immediately, and every register reads back 0 after release.
- Timer one-shot: LOAD=10, CTRL=1 -> `irq_o[0]` rises exactly 12 cycles after the CTRL write edge, and CTRL reads 0. Write STATUS=1 -> `irq_o[0]` falls 1 cycle later.
- Timer auto-reload: LOAD=4, CTRL=3, MASK=1, clear STATUS on every interrupt -> STATUS[0] sets every 5 cycles. A W1C on a set cycle leaves the bit at 1.
- Edge: EDGE=0x0000_0001 (rise on bit 0), MASK=0x100, drive `src_i[0]` 0->1 -> `irq_o[1]` rises 3 cycles later. A 1->0 transition does not set the bit. Enabling bit 16 makes the falling edge set it.
- Software IRQ and masking: SWSET=1 with MASK[31]=0 -> STATUS reads 0x8000_0000 and `irq_o[2]`=0. Set MASK[31]=1 -> `irq_o[2]`=1.
- Bus: read 0x1C -> `ack` with data 0. Access to `BASE_ADR`+0x100 -> no `ack`. A `sel`=4'b0001 write of 0xFFFF_FFFF to LOAD -> LOAD=0x0000_00FF.
